uart_rx: RTL



---
 rtl/uart_rx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: oversampled start/data/stop detection feeding a
// single-byte holding register with valid/read handshake and overrun flag.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       sample_ck,
    input  logic       rx,
    input  logic       re,
    output logic [7:0] out,
    output logic       valid,
    output logic       overrun,
    output logic       frame_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    nbit_q, nbit_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    out_q, out_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          ferr_q, ferr_d;
    logic          load;
    logic          rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nbit_d    = nbit_q;
        sh_d      = sh_q;
        ferr_d    = 1'b0;
        load      = 1'b0;
        if (sample_ck) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    // Mid-start re-check rejects glitches shorter than half a bit.
                    if (cnt_q == CNT_MID) begin
                        cnt_d  = '0;
                        nbit_d = 3'd0;
                        state_d = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_END) begin
                        sh_d  = {rx_s, sh_q[7:1]};
                        cnt_d = '0;
                        if (nbit_q == 3'd7) state_d = S_STOP;
                        else                nbit_d  = nbit_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_END) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            load    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A read coinciding with a load retires the old byte, so no overrun.
    always_comb begin
        out_d     = out_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load) begin
            out_d     = sh_q;
            valid_d   = 1'b1;
            overrun_d = valid_q & ~re;
        end else if (re && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            nbit_q    <= 3'd0;
            sh_q      <= 8'd0;
            out_q     <= 8'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nbit_q    <= nbit_d;
            sh_q      <= sh_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    assign out       = out_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = ferr_q;

endmodule
